// File: rtl/operand_loader_pkg.sv
// Shared definitions for the operand_loader front end.
//   STATE_W       : width of the state encoding shown on the board LEDs
//   DEFAULT_WIDTH : default operand width
//   state_e       : controller states; S_ERR is only reachable when the
//                   design is built with OPLD_TIMEOUT_EN defined
package operand_loader_pkg;

  localparam int STATE_W       = 3;
  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_GOT_A = 3'd1,
    S_RUN   = 3'd2,
    S_SHOW  = 3'd3,
    S_ERR   = 3'd4
  } state_e;

endpackage

// File: rtl/operand_loader_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and a
// rising-edge pulse on the debounced level.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   btn_raw : raw, asynchronous, bouncing button
//   press   : one-cycle pulse per accepted press (release edges give none)
// A clean rise of btn_raw yields press 2 + DEB_CYCLES cycles later.
module btn_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int                CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    // Any sample that agrees with the accepted level restarts the count,
    // so only an uninterrupted run of DEB_CYCLES disagreeing samples flips it.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/operand_loader.sv
// Front end for the 4-bit add/sub unit: walks the user through capturing
// operand A, then operand B plus mode switches, fires a one-cycle start,
// waits for flag_end and holds the result for display.
// Ports:
//   CLK_in, rst                     : clock, synchronous active-high reset
//   sw, btn_next                    : raw operand switches, raw button
//   sw_cin, sw_symbol, sw_add_min   : raw mode switches
//   flag_end                        : completion flag from the unit
//   a, b, cin, symbol, add_min      : registered operands / mode
//   start                           : one-cycle launch pulse
//   busy                            : high while waiting in S_RUN
//   err                             : watchdog fired
//   state_led                       : current state encoding
// Build option OPLD_TIMEOUT_EN: adds a RUN watchdog of TIMEOUT_CYCLES cycles
// leading to S_ERR. Without it S_RUN waits forever and err is tied low.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int DEB_CYCLES     = 1000000,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               CLK_in,
  input  logic               rst,
  input  logic [WIDTH-1:0]   sw,
  input  logic               btn_next,
  input  logic               sw_cin,
  input  logic               sw_symbol,
  input  logic               sw_add_min,
  input  logic               flag_end,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic               cin,
  output logic               symbol,
  output logic               add_min,
  output logic               start,
  output logic               busy,
  output logic               err,
  output logic [STATE_W-1:0] state_led
);

  if (DEB_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("DEB_CYCLES and TIMEOUT_CYCLES must both be at least 1");
  end

  logic press;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debounce (
    .clk     (CLK_in),
    .rst     (rst),
    .btn_raw (btn_next),
    .press   (press)
  );

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;
  logic             symbol_q, symbol_d;
  logic             add_min_q, add_min_d;
  logic             start_q, start_d;

`ifdef OPLD_TIMEOUT_EN
  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    cin_d     = cin_q;
    symbol_d  = symbol_q;
    add_min_d = add_min_q;
    start_d   = 1'b0;
`ifdef OPLD_TIMEOUT_EN
    err_d     = err_q;
    tmo_d     = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (press) begin
          a_d     = sw;
          state_d = S_GOT_A;
        end
      end
      S_GOT_A: begin
        if (press) begin
          b_d       = sw;
          cin_d     = sw_cin;
          symbol_d  = sw_symbol;
          add_min_d = sw_add_min;
          start_d   = 1'b1;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        // flag_end is ignored during the launch cycle itself so a flag still
        // high from the previous operation cannot end this one; presses are
        // ignored throughout, so a coincident press is simply dropped.
        if (flag_end && !start_q) begin
          state_d = S_SHOW;
`ifdef OPLD_TIMEOUT_EN
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
`endif
        end
      end
      S_SHOW: begin
        if (press) state_d = S_IDLE;
      end
`ifdef OPLD_TIMEOUT_EN
      S_ERR: begin
        if (press) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_in) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      symbol_q  <= 1'b0;
      add_min_q <= 1'b1;
      start_q   <= 1'b0;
`ifdef OPLD_TIMEOUT_EN
      err_q     <= 1'b0;
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cin_q     <= cin_d;
      symbol_q  <= symbol_d;
      add_min_q <= add_min_d;
      start_q   <= start_d;
`ifdef OPLD_TIMEOUT_EN
      err_q     <= err_d;
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign cin       = cin_q;
  assign symbol    = symbol_q;
  assign add_min   = add_min_q;
  assign start     = start_q;
  assign busy      = (state_q == S_RUN);
  assign state_led = state_q;
`ifdef OPLD_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_operand_loader.sv
module tb_operand_loader;

  localparam int DEB = 4;
  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw = '0;
  logic       btn_next = 1'b0;
  logic       sw_cin = 1'b0, sw_symbol = 1'b0, sw_add_min = 1'b0, flag_end = 1'b0;
  logic [3:0] a, b;
  logic       cin, symbol, add_min, start, busy, err;
  logic [2:0] state_led;

  operand_loader #(.WIDTH(4), .DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK_in(clk), .rst(rst), .sw(sw), .btn_next(btn_next), .sw_cin(sw_cin),
    .sw_symbol(sw_symbol), .sw_add_min(sw_add_min), .flag_end(flag_end),
    .a(a), .b(b), .cin(cin), .symbol(symbol), .add_min(add_min), .start(start),
    .busy(busy), .err(err), .state_led(state_led));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, start_cnt = 0;
  bit chk_en = 0;

  always @(posedge clk) if (start === 1'b1) start_cnt++;

  // Reference model: button accepted once the last DEB synchronised samples
  // all disagree with the accepted level; controller follows the user walk.
  bit m_s1, m_s2, m_lvl, m_press, m_start, m_err, m_cin, m_sym, m_addm = 1;
  bit win[$];
  logic [2:0] m_state = 0;
  logic [3:0] m_a, m_b;
  int m_age;

  always @(posedge clk) begin
    logic [2:0] nst;
    bit nstart, all_diff;
    if (rst) begin
      win.delete(); m_s1 = 0; m_s2 = 0; m_lvl = 0; m_press = 0; m_start = 0;
      m_err = 0; m_state = 0; m_a = 0; m_b = 0; m_cin = 0; m_sym = 0; m_addm = 1; m_age = 0;
    end else begin
      nst = m_state; nstart = 0;
      case (m_state)
        3'd0: if (m_press) begin m_a = sw; nst = 3'd1; end
        3'd1: if (m_press) begin
          m_b = sw; m_cin = sw_cin; m_sym = sw_symbol; m_addm = sw_add_min;
          nstart = 1; nst = 3'd2;
        end
        3'd2: begin
          m_age++;
          if (flag_end && !m_start) nst = 3'd3;
`ifdef OPLD_TIMEOUT_EN
          else if (m_age >= TMO) begin nst = 3'd4; m_err = 1; end
`endif
        end
        3'd3: if (m_press) nst = 3'd0;
`ifdef OPLD_TIMEOUT_EN
        3'd4: if (m_press) begin nst = 3'd0; m_err = 0; end
`endif
        default: nst = 3'd0;
      endcase
      if (nst != 3'd2) m_age = 0;
      win.push_back(m_s2);
      if (win.size() > DEB) void'(win.pop_front());
      all_diff = (win.size() == DEB);
      foreach (win[i]) if (win[i] == m_lvl) all_diff = 0;
      m_press = 0;
      if (all_diff) begin m_lvl = !m_lvl; m_press = m_lvl; win.delete(); end
      m_s2 = m_s1; m_s1 = btn_next;
      m_state = nst; m_start = nstart;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_en)
      check("cycle", 32'({state_led, a, b, cin, symbol, add_min, start, busy, err}),
            32'({m_state, m_a, m_b, m_cin, m_sym, m_addm, m_start, (m_state == 3'd2), m_err}));
  endtask

  task automatic hold_btn(input bit lvl, input int n);
    btn_next = lvl;
    repeat (n) tick();
  endtask

  task automatic press();
    hold_btn(1'b1, DEB + 3);
    hold_btn(1'b0, DEB + 3);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0] sw_a, sw_b;
    bit cin, sym, addm;
    int dly;
    logic [3:0] exp_a, exp_b;
    bit exp_cin, exp_sym, exp_addm;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat;
    vecs[0] = '{4'h3, 4'h9, 0, 0, 1, 3, 4'h3, 4'h9, 0, 0, 1};
    vecs[1] = '{4'hF, 4'hF, 1, 1, 1, 0, 4'hF, 4'hF, 1, 1, 1};
    vecs[2] = '{4'h0, 4'h0, 0, 0, 0, 1, 4'h0, 4'h0, 0, 0, 0};
    vecs[3] = '{4'h8, 4'h7, 1, 1, 0, 2, 4'h8, 4'h7, 1, 1, 0};
    vecs[4] = '{4'hA, 4'h5, 0, 1, 1, 4, 4'hA, 4'h5, 0, 1, 1};
    vecs[5] = '{4'h1, 4'hE, 1, 0, 0, 0, 4'h1, 4'hE, 1, 0, 0};

    // Reset values
    rst = 1'b1; tick(); tick();
    chk_en = 1;
    check("rst_state", state_led, 0); check("rst_a", a, 0); check("rst_b", b, 0);
    check("rst_cin", cin, 0); check("rst_symbol", symbol, 0); check("rst_add_min", add_min, 1);
    check("rst_start", start, 0); check("rst_busy", busy, 0); check("rst_err", err, 0);
    rst = 1'b0;

    // Bounce rejection
    sw = 4'b0101;
    for (int i = 0; i < 10; i++) hold_btn(i % 2 == 0, 2);
    check("bounce_no_press", state_led, 0);
    btn_next = 1'b1; lat = 0;
    for (int i = 0; i < 40 && state_led !== 3'd1; i++) begin tick(); lat++; end
    check("bounce_latency", lat, DEB + 3);
    check("bounce_state", state_led, 1); check("bounce_a", a, 4'b0101);
    hold_btn(1'b0, DEB + 3);
    do_reset();

    // Full add
    sw = 4'd3; press();
    check("add_got_a", state_led, 1); check("add_a", a, 3);
    sw = 4'd9; sw_add_min = 1; sw_cin = 0; sw_symbol = 0; start_cnt = 0;
    hold_btn(1'b1, DEB + 3);
    check("add_start", start, 1); check("add_run", state_led, 2);
    check("add_b", b, 9); check("add_busy", busy, 1);
    sw = 4'd12; tick();
    check("add_start_low", start, 0);
    tick(); flag_end = 1; tick(); flag_end = 0;
    check("add_show", state_led, 3); check("add_show_busy", busy, 0);
    check("add_hold_a", a, 3); check("add_hold_b", b, 9); check("add_start_cnt", start_cnt, 1);
    hold_btn(1'b0, DEB + 3);
    press();
    check("show_to_idle", state_led, 0); check("idle_keep_a", a, 3);

    // Second operation: press during RUN / watchdog
    sw = 4'd3; press();
    sw = 4'd12; start_cnt = 0;
    hold_btn(1'b1, DEB + 3);
    check("run2_state", state_led, 2);
`ifndef OPLD_TIMEOUT_EN
    hold_btn(1'b0, DEB + 3); press();
    check("run_press_ignored", state_led, 2); check("run_one_start", start_cnt, 1);
    check("run_no_err", err, 0); check("run_busy", busy, 1);
    hold_btn(1'b1, DEB + 2);
    flag_end = 1; tick(); flag_end = 0;
    check("simul_show", state_led, 3);
    hold_btn(1'b0, DEB + 3);
    press();
    check("simul_idle", state_led, 0); check("simul_keep_a", a, 3);
`else
    repeat (TMO - 1) tick();
    check("tmo_still_run", state_led, 2); check("tmo_no_err", err, 0);
    tick();
    check("tmo_err_state", state_led, 4); check("tmo_err", err, 1);
    hold_btn(1'b0, DEB + 3); press();
    check("err_idle", state_led, 0); check("err_clear", err, 0);
`endif

    // Reset mid-RUN
    sw = 4'd6; press(); sw = 4'd10; hold_btn(1'b1, DEB + 3);
    check("pre_rst_run", state_led, 2);
    rst = 1'b1; tick();
    check("rst_run_state", state_led, 0); check("rst_run_a", a, 0); check("rst_run_b", b, 0);
    check("rst_run_add_min", add_min, 1); check("rst_run_busy", busy, 0); check("rst_run_start", start, 0);
    rst = 1'b0; btn_next = 1'b0;
    hold_btn(1'b0, DEB + 3);
    do_reset();

    // Operand table
    foreach (vecs[k]) begin
      sw = vecs[k].sw_a; press();
      sw = vecs[k].sw_b; sw_cin = vecs[k].cin; sw_symbol = vecs[k].sym; sw_add_min = vecs[k].addm;
      flag_end = (vecs[k].dly == 0);
      hold_btn(1'b1, DEB + 3);
      sw = 4'($urandom); sw_cin = 1'($urandom); sw_symbol = 1'($urandom); sw_add_min = 1'($urandom);
      repeat (vecs[k].dly) tick();
      flag_end = 1; tick(); tick(); flag_end = 0;
      check("vec_state", state_led, 3); check("vec_a", a, vecs[k].exp_a); check("vec_b", b, vecs[k].exp_b);
      check("vec_cin", cin, vecs[k].exp_cin); check("vec_symbol", symbol, vecs[k].exp_sym);
      check("vec_add_min", add_min, vecs[k].exp_addm);
      hold_btn(1'b0, DEB + 3);
      sw = 4'($urandom); press();
      check("vec_idle", state_led, 0); check("vec_keep_a", a, vecs[k].exp_a); check("vec_keep_b", b, vecs[k].exp_b);
    end

    // Random walk against the model
    for (int seg = 0; seg < 600; seg++) begin
      int len;
      btn_next = 1'($urandom);
      len = $urandom_range(1, 12);
      for (int c = 0; c < len; c++) begin
        sw = 4'($urandom); sw_cin = 1'($urandom); sw_symbol = 1'($urandom);
        sw_add_min = 1'($urandom); flag_end = ($urandom_range(0, 4) == 0);
        rst = ($urandom_range(0, 299) == 0);
        tick();
      end
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
